// File: rtl/mips_id_rf_wport_arb.sv
// Register-file write-port owner: WB-priority arbitration against a queued
// long-latency result FIFO, plus a busy scoreboard for reserved destinations.
module mips_id_rf_wport_arb #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned IDX_W      = 5,
  parameter int unsigned DAT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_req_en,
  input  logic [IDX_W-1:0] wb_req_idx,
  input  logic [DAT_W-1:0] wb_req_dat,
  input  logic             lu_issue_vld,
  input  logic [IDX_W-1:0] lu_issue_idx,
  output logic             lu_issue_rdy,
  input  logic             lu_res_vld,
  output logic             lu_res_rdy,
  input  logic [IDX_W-1:0] lu_res_idx,
  input  logic [DAT_W-1:0] lu_res_dat,
  input  logic [IDX_W-1:0] chk_rs_idx,
  input  logic [IDX_W-1:0] chk_rt_idx,
  output logic             chk_rs_busy,
  output logic             chk_rt_busy,
  output logic             wb_hold,
  output logic             err_waw,
  output logic             wb_dest_en,
  output logic [IDX_W-1:0] wb_dest_idx,
  output logic [DAT_W-1:0] wb_dest_dat
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned NREG  = 1 << IDX_W;

  logic [IDX_W-1:0] mem_idx [DEPTH];
  logic [DAT_W-1:0] mem_dat [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             hold_q, hold_d;
  logic             err_q, err_d;
  logic             en_q, en_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DAT_W-1:0] dat_q, dat_d;

  logic             full, empty, push, pop, issue_fire;
  logic [IDX_W-1:0] head_idx;
  logic [DAT_W-1:0] head_dat;

  // Handshakes and hazard queries, all from registered state
  always_comb begin
    full         = (cnt_q == CNT_W'(DEPTH));
    empty        = (cnt_q == '0);
    push         = lu_res_vld & ~full;
    pop          = ~wb_req_en & ~empty;
    head_idx     = mem_idx[rd_ptr_q];
    head_dat     = mem_dat[rd_ptr_q];
    lu_res_rdy   = ~full;
    lu_issue_rdy = (lu_issue_idx == '0) | ~busy_q[lu_issue_idx];
    issue_fire   = lu_issue_vld & lu_issue_rdy & (lu_issue_idx != '0);
    chk_rs_busy  = (chk_rs_idx != '0) & busy_q[chk_rs_idx];
    chk_rt_busy  = (chk_rt_idx != '0) & busy_q[chk_rt_idx];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    busy_d   = busy_q;
    err_d    = err_q;
    en_d     = 1'b0;
    idx_d    = idx_q;
    dat_d    = dat_q;
    age_d    = age_q;

    if (wb_req_en) begin
      en_d  = (wb_req_idx != '0);
      idx_d = wb_req_idx;
      dat_d = wb_req_dat;
      if ((wb_req_idx != '0) && busy_q[wb_req_idx]) err_d = 1'b1;
    end else if (pop) begin
      en_d             = (head_idx != '0);
      idx_d            = head_idx;
      dat_d            = head_dat;
      busy_d[head_idx] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if ((lu_res_idx != '0) && !busy_q[lu_res_idx]) err_d = 1'b1;
    end

    // A fresh reservation wins over a clear of an unreserved stray result
    if (issue_fire) busy_d[lu_issue_idx] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (pop || empty)                   age_d = '0;
    else if (age_q < AGE_W'(STARVE_MAX)) age_d = age_q + AGE_W'(1);
    hold_d = (age_d >= AGE_W'(STARVE_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
      age_q    <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      idx_q    <= '0;
      dat_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      age_q    <= age_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      en_q     <= en_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx[wr_ptr_q] <= lu_res_idx;
      mem_dat[wr_ptr_q] <= lu_res_dat;
    end
  end

  assign wb_hold     = hold_q;
  assign err_waw     = err_q;
  assign wb_dest_en  = en_q;
  assign wb_dest_idx = idx_q;
  assign wb_dest_dat = dat_q;

endmodule

// File: tb/tb_mips_id_rf_wport_arb.sv
// Directed + randomized bench for mips_id_rf_wport_arb against a queue-based
// reference model of the write-port arbiter.
module tb_mips_id_rf_wport_arb;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_req_en;
  logic [4:0]  wb_req_idx;
  logic [31:0] wb_req_dat;
  logic        lu_issue_vld;
  logic [4:0]  lu_issue_idx;
  logic        lu_issue_rdy;
  logic        lu_res_vld;
  logic        lu_res_rdy;
  logic [4:0]  lu_res_idx;
  logic [31:0] lu_res_dat;
  logic [4:0]  chk_rs_idx, chk_rt_idx;
  logic        chk_rs_busy, chk_rt_busy;
  logic        wb_hold, err_waw, wb_dest_en;
  logic [4:0]  wb_dest_idx;
  logic [31:0] wb_dest_dat;

  mips_id_rf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .IDX_W(5), .DAT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_req_en(wb_req_en), .wb_req_idx(wb_req_idx), .wb_req_dat(wb_req_dat),
    .lu_issue_vld(lu_issue_vld), .lu_issue_idx(lu_issue_idx), .lu_issue_rdy(lu_issue_rdy),
    .lu_res_vld(lu_res_vld), .lu_res_rdy(lu_res_rdy), .lu_res_idx(lu_res_idx), .lu_res_dat(lu_res_dat),
    .chk_rs_idx(chk_rs_idx), .chk_rt_idx(chk_rt_idx),
    .chk_rs_busy(chk_rs_busy), .chk_rt_busy(chk_rt_busy),
    .wb_hold(wb_hold), .err_waw(err_waw),
    .wb_dest_en(wb_dest_en), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
  } ent_t;

  ent_t        mq[$];
  bit          mbusy[32];
  int          mage;
  bit          mhold, merr, men;
  logic [4:0]  midx;
  logic [31:0] mdat;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [4:0]  pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mage = 0; mhold = 0; merr = 0; men = 0; midx = '0; mdat = '0;
  endtask

  task automatic idle();
    wb_req_en = 0; wb_req_idx = '0; wb_req_dat = '0;
    lu_issue_vld = 0; lu_issue_idx = '0;
    lu_res_vld = 0; lu_res_idx = '0; lu_res_dat = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_en"},   32'(wb_dest_en),  32'(0));
    chk({tag, "_idx"},  32'(wb_dest_idx), 32'(0));
    chk({tag, "_dat"},  wb_dest_dat,      32'(0));
    chk({tag, "_hold"}, 32'(wb_hold),     32'(0));
    chk({tag, "_err"},  32'(err_waw),     32'(0));
    chk({tag, "_rdy"},  32'(lu_res_rdy),  32'(1));
  endtask

  // One cycle: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    bit   pre_busy[32];
    bit   res_rdy, iss_rdy, pop;
    ent_t h;
    #1;
    res_rdy = (mq.size() < DEPTH);
    iss_rdy = (lu_issue_idx == 0) || !mbusy[lu_issue_idx];
    chk("res_rdy",   32'(lu_res_rdy),   32'(res_rdy));
    chk("issue_rdy", 32'(lu_issue_rdy), 32'(iss_rdy));
    chk("rs_busy",   32'(chk_rs_busy),  32'((chk_rs_idx != 0) && mbusy[chk_rs_idx]));
    chk("rt_busy",   32'(chk_rt_busy),  32'((chk_rt_idx != 0) && mbusy[chk_rt_idx]));

    pre_busy = mbusy;
    pop = !wb_req_en && (mq.size() > 0);
    if (pop || mq.size() == 0) mage = 0;
    else if (mage < STARVE_MAX) mage++;

    if (wb_req_en) begin
      men = (wb_req_idx != 0); midx = wb_req_idx; mdat = wb_req_dat;
      if (wb_req_idx != 0 && pre_busy[wb_req_idx]) merr = 1;
    end else if (pop) begin
      h = mq.pop_front();
      men = (h.idx != 0); midx = h.idx; mdat = h.dat;
      mbusy[h.idx] = 0;
    end else begin
      men = 0;
    end
    if (lu_res_vld && res_rdy) begin
      if (lu_res_idx != 0 && !pre_busy[lu_res_idx]) merr = 1;
      mq.push_back('{idx: lu_res_idx, dat: lu_res_dat});
    end
    if (lu_issue_vld && iss_rdy && lu_issue_idx != 0) mbusy[lu_issue_idx] = 1;
    mbusy[0] = 0;
    mhold = (mage >= STARVE_MAX);

    @(posedge clk); #1;
    chk("dest_en",  32'(wb_dest_en),  32'(men));
    if (men) begin
      chk("dest_idx", 32'(wb_dest_idx), 32'(midx));
      chk("dest_dat", wb_dest_dat,      mdat);
    end
    chk("hold", 32'(wb_hold), 32'(mhold));
    chk("err",  32'(err_waw), 32'(merr));
  endtask

  initial begin
    idle();
    chk_rs_idx = '0; chk_rt_idx = '0;
    rst_n = 1'b0;
    model_reset();
    #13;
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WB only
    wb_req_en = 1; wb_req_idx = 5'd5; wb_req_dat = 32'hDEADBEEF;
    step();
    chk("wb5_en",  32'(wb_dest_en), 32'(1));
    chk("wb5_dat", wb_dest_dat, 32'hDEADBEEF);
    idle(); step();

    // Reserve 7, blocked re-issue, result and drain
    chk_rs_idx = 5'd7;
    lu_issue_vld = 1; lu_issue_idx = 5'd7; step();
    step();  // second issue to 7 while busy
    idle(); step();
    lu_res_vld = 1; lu_res_idx = 5'd7; lu_res_dat = 32'h12345678; step();
    idle(); step();
    chk("r7_idx", 32'(wb_dest_idx), 32'(7));
    step();

    // Starvation: result 9 waits behind continuous WB until a bubble
    chk_rt_idx = 5'd9;
    lu_issue_vld = 1; lu_issue_idx = 5'd9; wb_req_en = 1; wb_req_idx = 5'd20; wb_req_dat = 32'h1;
    step();
    lu_issue_vld = 0; lu_res_vld = 1; lu_res_idx = 5'd9; lu_res_dat = 32'hA;
    step();
    lu_res_vld = 0;
    for (int c = 0; c < 8; c++) begin
      wb_req_en = !mhold; wb_req_dat = 32'(c + 2);
      step();
    end

    // Full FIFO under continuous WB: three results in order
    idle();
    for (int i = 1; i <= 3; i++) begin
      lu_issue_vld = 1; lu_issue_idx = 5'(i); step();
    end
    lu_issue_vld = 0;
    begin
      int k = 1;
      for (int c = 0; c < 24 && (k <= 3 || mq.size() > 0); c++) begin
        wb_req_en = !mhold; wb_req_idx = 5'd21; wb_req_dat = 32'(100 + c);
        lu_res_vld = (k <= 3); lu_res_idx = 5'(k); lu_res_dat = 32'hC0DE_0000 + 32'(k);
        if (lu_res_vld && mq.size() < DEPTH) begin
          step(); k++;
        end else step();
      end
      chk("full_drained", 32'(mq.size()), 32'(0));
    end

    // Index 0: never reserved, pops with en=0, no error
    idle();
    lu_issue_vld = 1; lu_issue_idx = 5'd0; step();
    lu_issue_vld = 0; lu_res_vld = 1; lu_res_idx = 5'd0; lu_res_dat = 32'hFFFF; step();
    idle(); step();
    chk("idx0_en",  32'(wb_dest_en), 32'(0));
    chk("idx0_err", 32'(err_waw),    32'(0));

    // Async reset with two queued results and a live reservation
    chk_rs_idx = 5'd3;
    for (int i = 3; i <= 5; i++) begin
      lu_issue_vld = 1; lu_issue_idx = 5'(i); step();
    end
    lu_issue_vld = 0; wb_req_en = 1; wb_req_idx = 5'd22;
    lu_res_vld = 1; lu_res_idx = 5'd4; lu_res_dat = 32'h44; step();
    lu_res_idx = 5'd5; lu_res_dat = 32'h55; step();
    idle();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_reset_state("async");
    chk("async_busy3", 32'(chk_rs_busy), 32'(0));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      wb_req_en  = mhold ? 1'b0 : ($urandom_range(0, 2) != 0);
      wb_req_idx = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(8, 31));
      wb_req_dat = $urandom;
      lu_issue_vld = ($urandom_range(0, 2) == 0);
      lu_issue_idx = 5'($urandom_range(0, 7));
      if (lu_issue_vld && lu_issue_idx != 0 && !mbusy[lu_issue_idx]) pend.push_back(lu_issue_idx);
      lu_res_dat = $urandom;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        lu_res_vld = 1; lu_res_idx = pend[0];
        if (mq.size() < DEPTH) void'(pend.pop_front());
      end else begin
        lu_res_vld = ($urandom_range(0, 29) == 0);
        lu_res_idx = 5'($urandom_range(0, 31));
      end
      chk_rs_idx = 5'($urandom_range(0, 7));
      chk_rt_idx = 5'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
